// File: rtl/note_lane_pkg.sv
// note_lane_pkg
//   Shared types and constants for the rhythm-game note field.
//   rgb_t       : 6-bit pixel colour (2 bits per channel)
//   BLACK       : empty pixel
//   BAND_GRAY   : hit-window band background
//   FLASH_WHITE : hit-window band flash after a successful hit
//   COMBO_W     : width of the combo counter
package note_lane_pkg;

   typedef logic [5:0] rgb_t;

   localparam rgb_t BLACK       = 6'b000000;
   localparam rgb_t BAND_GRAY   = 6'b010101;
   localparam rgb_t FLASH_WHITE = 6'b111111;

   localparam int COMBO_W = 8;

endpackage

// File: rtl/note_lane_array_btn_sync_edge.sv
// btn_sync_edge
//   Two-flop synchroniser for one raw player button followed by a
//   rising-edge detector. rise is high for exactly one cycle per synced
//   low-to-high transition, so a held button produces a single pulse.
//   Ports:
//     clk   in  pixel clock
//     rst_n in  asynchronous active-low reset
//     btn   in  raw asynchronous button, active-high
//     rise  out one-cycle pulse on the synced rising edge
module btn_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   logic meta_p0;
   logic sync_p1;
   logic sync_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         meta_p0 <= btn;
         sync_p1 <= meta_p0;
         sync_p2 <= sync_p1;
      end
   end

   assign rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/note_lane_array.sv
// note_lane_array
//   Multi-lane note field. Notes scroll down LANES lanes of DEPTH cells,
//   advancing one cell every STEP_DIV frame ticks. Button presses are
//   judged against the hit window HIT_LO..HIT_HI; score and combo track
//   hits. A registered per-pixel colour is produced for the VGA mux.
//   Optional feature: define NOTE_LANE_HIT_FLASH_EN to flash a lane's hit
//   band white for 7 frames after each hit in that lane.
//   Ports:
//     clk        in  pixel clock
//     rst_n      in  asynchronous active-low reset
//     col, row   in  current pixel coordinates (10 bits each)
//     valid      in  pixel is inside the visible area
//     frame_tick in  one-cycle pulse per frame
//     drop       in  per-lane note spawn request
//     btn        in  raw asynchronous player buttons
//     lane_color in  packed per-lane note colour, lane i at [6i+5:6i]
//     lane_rgb   out registered pixel colour
//     hit        out per-lane one-cycle hit pulse
//     miss       out per-lane one-cycle miss pulse
//     score      out saturating hit count
//     combo      out saturating consecutive-hit count
module note_lane_array
   import note_lane_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int DEPTH    = 96,
   parameter int CELL_H   = 5,
   parameter int LANE_W   = 160,
   parameter int STEP_DIV = 1,
   parameter int HIT_LO   = 88,
   parameter int HIT_HI   = 95,
   parameter int SCORE_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [9:0]           col,
   input  logic [9:0]           row,
   input  logic                 valid,
   input  logic                 frame_tick,
   input  logic [LANES-1:0]     drop,
   input  logic [LANES-1:0]     btn,
   input  logic [LANES*6-1:0]   lane_color,
   output logic [5:0]           lane_rgb,
   output logic [LANES-1:0]     hit,
   output logic [LANES-1:0]     miss,
   output logic [SCORE_W-1:0]   score,
   output logic [COMBO_W-1:0]   combo
);

   localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int CNT_W  = $clog2(LANES + 1);
   localparam int CIDX_W = $clog2(DEPTH);

   localparam logic [9:0]        LANE_W10  = 10'(LANE_W);
   localparam logic [9:0]        CELL_H10  = 10'(CELL_H);
   localparam logic [9:0]        DEPTH10   = 10'(DEPTH);
   localparam logic [9:0]        HIT_LO10  = 10'(HIT_LO);
   localparam logic [9:0]        HIT_HI10  = 10'(HIT_HI);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

   function automatic logic [CNT_W-1:0] count_ones(input logic [LANES-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] s,
                                                        input logic [CNT_W-1:0]   n);
      logic [SCORE_W:0] sum;
      sum = {1'b0, s} + (SCORE_W + 1)'(n);
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

   function automatic logic [COMBO_W-1:0] sat_add_combo(input logic [COMBO_W-1:0] c,
                                                        input logic [CNT_W-1:0]   n);
      logic [COMBO_W:0] sum;
      sum = {1'b0, c} + (COMBO_W + 1)'(n);
      return sum[COMBO_W] ? {COMBO_W{1'b1}} : sum[COMBO_W-1:0];
   endfunction

   logic [LANES-1:0]  rise;
   logic [DEPTH-1:0]  cells     [LANES];
   logic [DEPTH-1:0]  cells_nxt [LANES];
   logic [LANES-1:0]  pending;
   logic [LANES-1:0]  pending_nxt;
   logic [LANES-1:0]  hit_nxt;
   logic [LANES-1:0]  miss_nxt;
   logic [LANES-1:0]  wrong_nxt;
   logic [CNT_W-1:0]  hit_cnt;
   logic [STEP_W-1:0] step_cnt;
   logic              advance;
   logic [LANES-1:0]  flash_on;

   // Stage p0: button synchronisers
   for (genvar g = 0; g < LANES; g++) begin : g_btn
      btn_sync_edge u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .btn   (btn[g]),
         .rise  (rise[g])
      );
   end

   assign advance = frame_tick && (step_cnt == STEP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_cnt <= '0;
      end else if (frame_tick) begin
         step_cnt <= advance ? '0 : step_cnt + STEP_W'(1);
      end
   end

   // Stage p1: judgement on pre-advance contents, then clear, then shift
   always_comb begin
      logic             found;
      logic [DEPTH-1:0] clr;
      logic [DEPTH-1:0] kept;
      hit_nxt     = '0;
      miss_nxt    = '0;
      wrong_nxt   = '0;
      pending_nxt = pending;
      cells_nxt   = cells;
      found       = 1'b0;
      clr         = '0;
      kept        = '0;
      for (int i = 0; i < LANES; i++) begin
         found = 1'b0;
         clr   = '0;
         // Ascending scan keeps the last match, i.e. the note closest to the bottom.
         for (int k = HIT_LO; k <= HIT_HI; k++) begin
            if (cells[i][k]) begin
               found  = 1'b1;
               clr    = '0;
               clr[k] = 1'b1;
            end
         end
         hit_nxt[i]   = rise[i] & found;
         wrong_nxt[i] = rise[i] & ~found;
         kept         = cells[i] & ~({DEPTH{hit_nxt[i]}} & clr);
         if (advance) begin
            cells_nxt[i]   = {kept[DEPTH-2:0], pending[i] | drop[i]};
            miss_nxt[i]    = kept[DEPTH-1];
            pending_nxt[i] = 1'b0;
         end else begin
            cells_nxt[i]   = kept;
            pending_nxt[i] = pending[i] | drop[i];
         end
      end
   end

   assign hit_cnt = count_ones(hit_nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) cells[i] <= '0;
         pending <= '0;
         hit     <= '0;
         miss    <= '0;
         score   <= '0;
         combo   <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) cells[i] <= cells_nxt[i];
         pending <= pending_nxt;
         hit     <= hit_nxt;
         miss    <= miss_nxt;
         score   <= sat_add_score(score, hit_cnt);
         if ((|miss_nxt) || (|wrong_nxt)) combo <= '0;
         else                             combo <= sat_add_combo(combo, hit_cnt);
      end
   end

`ifdef NOTE_LANE_HIT_FLASH_EN
   logic [2:0] flash [LANES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) flash[i] <= 3'd0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (hit_nxt[i])                        flash[i] <= 3'd7;
            else if (frame_tick && flash[i] != 0)  flash[i] <= flash[i] - 3'd1;
         end
      end
   end

   always_comb begin
      flash_on = '0;
      for (int i = 0; i < LANES; i++) flash_on[i] = (flash[i] != 3'd0);
   end
`else
   assign flash_on = '0;
`endif

   // Stage p0: pixel lookup
   logic [9:0]       lane_idx_p0;
   logic [9:0]       cidx_p0;
   logic [DEPTH-1:0] sel_cells_p0;
   rgb_t             sel_color_p0;
   logic             sel_flash_p0;
   logic             lane_ok_p0;
   logic             in_field_p0;
   logic             in_band_p0;
   rgb_t             pix_p0;

   assign lane_idx_p0 = col / LANE_W10;
   assign cidx_p0     = row / CELL_H10;

   always_comb begin
      sel_cells_p0 = '0;
      sel_color_p0 = BLACK;
      sel_flash_p0 = 1'b0;
      lane_ok_p0   = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_idx_p0 == 10'(i)) begin
            lane_ok_p0   = 1'b1;
            sel_cells_p0 = cells[i];
            sel_color_p0 = lane_color[6*i +: 6];
            sel_flash_p0 = flash_on[i];
         end
      end
      in_field_p0 = lane_ok_p0 && (cidx_p0 < DEPTH10);
      in_band_p0  = (cidx_p0 >= HIT_LO10) && (cidx_p0 <= HIT_HI10);
      pix_p0      = BLACK;
      if (valid && in_field_p0) begin
         if (sel_cells_p0[cidx_p0[CIDX_W-1:0]]) pix_p0 = sel_color_p0;
         else if (in_band_p0)                   pix_p0 = sel_flash_p0 ? FLASH_WHITE : BAND_GRAY;
      end
   end

   // Stage p1: registered pixel output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lane_rgb <= BLACK;
      else        lane_rgb <= pix_p0;
   end

endmodule

// File: tb/tb_note_lane_array.sv
module tb_note_lane_array;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  col;
   logic [9:0]  row;
   logic        valid;
   logic        frame_tick;
   logic [3:0]  drop;
   logic [3:0]  btn;
   logic [23:0] lane_color;
   logic [5:0]  lane_rgb;
   logic [3:0]  hit;
   logic [3:0]  miss;
   logic [15:0] score;
   logic [7:0]  combo;

   always #5 clk = ~clk;

   note_lane_array dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .col        (col),
      .row        (row),
      .valid      (valid),
      .frame_tick (frame_tick),
      .drop       (drop),
      .btn        (btn),
      .lane_color (lane_color),
      .lane_rgb   (lane_rgb),
      .hit        (hit),
      .miss       (miss),
      .score      (score),
      .combo      (combo)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sbq[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   localparam logic [5:0] GRAY  = 6'b010101;
   localparam logic [5:0] WHITE = 6'b111111;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_assert++;
      if (sbq.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_underflow: observed %0h with no expected entry", obs);
         return;
      end
      e = sbq.pop_front();
      assert (obs === e.val)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
   endtask

   task automatic advance(input logic [3:0] d);
      drop       = d;
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      drop       = '0;
   endtask

   task automatic advance_n(input int n, output int misses);
      misses = 0;
      repeat (n) begin
         advance(4'b0000);
         if (miss != 4'b0000) misses++;
      end
   endtask

   task automatic pixel(input logic [9:0] c, input logic [9:0] r, input logic v);
      col   = c;
      row   = r;
      valid = v;
      tick();
   endtask

   task automatic press(input logic [3:0] b);
      btn = b;
      repeat (3) tick();
   endtask

   task automatic release_btn();
      btn = '0;
      repeat (3) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int m;
      int cyc;

      rst_n      = 1'b0;
      col        = '0;
      row        = '0;
      valid      = 1'b0;
      frame_tick = 1'b0;
      drop       = '0;
      btn        = '0;
      lane_color = {6'b110000, 6'b001111, 6'b001100, 6'b000011};

      // reset state
      repeat (3) tick();
      expect_val("rst_rgb", 0);   check(lane_rgb);
      expect_val("rst_hit", 0);   check(hit);
      expect_val("rst_miss", 0);  check(miss);
      expect_val("rst_score", 0); check(score);
      expect_val("rst_combo", 0); check(combo);
      #2 rst_n = 1'b1;
      tick();

      // miss path on lane 0
      advance(4'b0001);
      advance_n(95, m);
      expect_val("miss_early", 0); check(m);
      expect_val("px_note_l0_c95", 6'b000011);
      pixel(10'd10, 10'd477, 1'b1);
      check(lane_rgb);
      expect_val("px_band_l0_empty", GRAY);
      pixel(10'd10, 10'd445, 1'b1);
      check(lane_rgb);
      expect_val("miss_pulse", 4'b0001);
      expect_val("miss_combo", 0);
      expect_val("miss_score", 0);
      advance(4'b0000);
      check(miss); check(combo); check(score);
      expect_val("miss_pulse_end", 0);
      tick();
      check(miss);

      // hit path on lane 1
      advance(4'b0010);
      advance_n(90, m);
      expect_val("hit_path_no_miss", 0); check(m);
      expect_val("hit_latency", 3);
      expect_val("hit_lane1", 4'b0010);
      expect_val("hit_score", 1);
      expect_val("hit_combo", 1);
      btn[1] = 1'b1;
      cyc = -1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (hit != 4'b0000) begin
            cyc = c;
            break;
         end
      end
      check(cyc); check(hit); check(score); check(combo);
      expect_val("hit_pulse_end", 0);
      tick();
      check(hit);
      btn = '0;
      advance_n(6, m);
      expect_val("hit_no_later_miss", 0); check(m);
`ifdef NOTE_LANE_HIT_FLASH_EN
      expect_val("px_band_l1_cleared", WHITE);
`else
      expect_val("px_band_l1_cleared", GRAY);
`endif
      pixel(10'd200, 10'd452, 1'b1);
      check(lane_rgb);

      // two lanes hit in the same cycle
      advance(4'b1001);
      advance_n(90, m);
      expect_val("multi_no_miss", 0); check(m);
      expect_val("multi_hit", 4'b1001);
      expect_val("multi_score", 3);
      expect_val("multi_combo", 3);
      press(4'b1001);
      check(hit); check(score); check(combo);
      release_btn();

      // wrong press on empty lane 2
      expect_val("wrong_hit", 0);
      expect_val("wrong_combo", 0);
      expect_val("wrong_score", 3);
      press(4'b0100);
      check(hit); check(combo); check(score);
      release_btn();

      // press judged on the same cycle as an advance, note at cell 95
      advance(4'b0100);
      advance_n(95, m);
      expect_val("same_pre_miss", 0); check(m);
      expect_val("same_hit", 4'b0100);
      expect_val("same_miss", 0);
      expect_val("same_score", 4);
      expect_val("same_combo", 1);
      btn = 4'b0100;
      tick();
      tick();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      check(hit); check(miss); check(score); check(combo);
      btn = '0;
      advance_n(3, m);
      expect_val("same_no_later_miss", 0); check(m);

      // pixel mux, note in lane 3 at cell 10
      advance(4'b1000);
      advance_n(10, m);
      expect_val("px_note_l3", 6'b110000);
      pixel(10'd500, 10'd52, 1'b1);
      check(lane_rgb);
      expect_val("px_empty_l3", 0);
      pixel(10'd500, 10'd57, 1'b1);
      check(lane_rgb);
      expect_val("px_band_l3", GRAY);
      pixel(10'd500, 10'd445, 1'b1);
      check(lane_rgb);
      expect_val("px_invalid", 0);
      pixel(10'd500, 10'd52, 1'b0);
      check(lane_rgb);
      expect_val("px_lane_oob", 0);
      pixel(10'd640, 10'd52, 1'b1);
      check(lane_rgb);
      expect_val("px_row_oob", 0);
      pixel(10'd500, 10'd480, 1'b1);
      check(lane_rgb);

`ifdef NOTE_LANE_HIT_FLASH_EN
      // hit band flash on lane 0
      advance(4'b0001);
      advance_n(90, m);
      expect_val("flash_hit", 4'b0001);
      press(4'b0001);
      check(hit);
      btn = '0;
      expect_val("flash_on_0", WHITE);
      pixel(10'd10, 10'd445, 1'b1);
      check(lane_rgb);
      for (int k = 1; k <= 6; k++) begin
         advance(4'b0000);
         expect_val("flash_on_k", WHITE);
         pixel(10'd10, 10'd445, 1'b1);
         check(lane_rgb);
      end
      advance(4'b0000);
      expect_val("flash_off", GRAY);
      pixel(10'd10, 10'd445, 1'b1);
      check(lane_rgb);
`endif

      // asynchronous reset mid-scroll with a note on screen
      advance(4'b0001);
      advance_n(50, m);
      expect_val("pre_rst_px", 6'b000011);
      pixel(10'd10, 10'd252, 1'b1);
      check(lane_rgb);
      #2 rst_n = 1'b0;
      #1;
      expect_val("arst_rgb", 0);   check(lane_rgb);
      expect_val("arst_score", 0); check(score);
      expect_val("arst_combo", 0); check(combo);
      expect_val("arst_hit", 0);   check(hit);
      expect_val("arst_miss", 0);  check(miss);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      expect_val("post_rst_px", 0);
      pixel(10'd10, 10'd252, 1'b1);
      check(lane_rgb);
      advance_n(100, m);
      expect_val("post_rst_no_miss", 0); check(m);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
